// File: rtl/trig_channel_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module      : trig_channel_scheduler_if
//  Description : Per-channel ADC sample request bus (valid/data/ready).
//  Revision    : 1.0 - initial release
// ============================================================================
interface trig_channel_scheduler_if #(
    parameter int NUM_CHANNELS = 16,
    parameter int ADC_WIDTH    = 12
);
    logic [NUM_CHANNELS-1:0]           req_valid;
    logic [NUM_CHANNELS*ADC_WIDTH-1:0] req_data;
    logic [NUM_CHANNELS-1:0]           req_ready;

    modport master (output req_valid, output req_data, input req_ready);
    modport slave  (input req_valid, input req_data, output req_ready);
endinterface
`default_nettype wire

// File: rtl/trig_channel_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : trig_channel_scheduler
//  Description : Round-robin ADC channel arbiter feeding the trigger engine,
//                with channel tagging and arm/holdoff/single-shot control.
//  Revision    : 1.0 - initial release
// ============================================================================
module trig_channel_scheduler #(
    parameter int  NUM_CHANNELS = 16,
    parameter int  ADC_WIDTH    = 12,
    parameter int  ENGINE_LAT   = 2,
    localparam int CW           = $clog2(NUM_CHANNELS)
) (
    input  wire                      clk,
    input  wire                      rst_n,
    trig_channel_scheduler_if.slave  req,
    input  wire [NUM_CHANNELS-1:0]   chan_mask,
    input  wire                      arm,
    input  wire                      abort,
    input  wire                      single_shot,
    input  wire [15:0]               holdoff_cycles,
    output logic [ADC_WIDTH-1:0]     data_in,
    output logic [CW-1:0]            channel_in,
    output logic                     data_valid,
    input  wire                      trigger_valid,
    input  wire                      trigger_out,
    input  wire [7:0]                trigger_confidence,
    output logic                     evt_valid,
    output logic [CW-1:0]            evt_channel,
    output logic [7:0]               evt_confidence,
    output logic [1:0]               state_o,
    output logic [15:0]              sample_count
);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_ARMED   = 2'd1;
    localparam logic [1:0] c_ST_HOLDOFF = 2'd2;
    localparam logic [1:0] c_ST_DONE    = 2'd3;

    logic [1:0]              r_state;
    logic [1:0]              w_state_nxt;
    logic [15:0]             r_holdoff;
    logic [CW-1:0]           r_last_grant;
    logic [NUM_CHANNELS-1:0] w_elig;
    logic                    w_found;
    logic [CW-1:0]           w_grant_idx;
    logic [ADC_WIDTH-1:0]    w_sel_data;
    logic                    w_issue;
    logic                    w_arm_go;
    logic                    w_xfer;
    logic                    w_accept;

    logic [ADC_WIDTH-1:0]    r_data_in;
    logic [CW-1:0]           r_channel_in;
    logic                    r_data_valid;
    logic                    r_evt_valid;
    logic [CW-1:0]           r_evt_channel;
    logic [7:0]              r_evt_confidence;
    logic [15:0]             r_sample_count;

    logic [ENGINE_LAT-1:0]   r_tag_valid;
    logic [CW-1:0]           r_tag_chan [ENGINE_LAT];

    // ---------------- state machine ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= c_ST_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = c_ST_IDLE;
        end else begin
            case (r_state)
                c_ST_IDLE, c_ST_DONE: if (arm)      w_state_nxt = c_ST_ARMED;
                c_ST_ARMED:           if (w_accept) w_state_nxt = single_shot ? c_ST_DONE : c_ST_HOLDOFF;
                c_ST_HOLDOFF:         if (r_holdoff == 16'd0) w_state_nxt = c_ST_ARMED;
                default:              w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    always_comb begin
        w_issue  = (r_state == c_ST_ARMED) || (r_state == c_ST_HOLDOFF);
        w_arm_go = arm && !abort && ((r_state == c_ST_IDLE) || (r_state == c_ST_DONE));
        state_o  = r_state;
    end

    // ---------------- arbitration ----------------
    assign w_elig = req.req_valid & chan_mask;

    // Search wraps naturally because CW-bit addition is modulo NUM_CHANNELS.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        for (int k = 1; k <= NUM_CHANNELS; k++) begin
            if (!w_found && w_elig[r_last_grant + CW'(k)]) begin
                w_found     = 1'b1;
                w_grant_idx = r_last_grant + CW'(k);
            end
        end
    end

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (w_grant_idx == CW'(i)) w_sel_data = req.req_data[i*ADC_WIDTH +: ADC_WIDTH];
        end
    end

    assign w_xfer        = w_issue && w_found;
    assign req.req_ready = w_xfer ? (NUM_CHANNELS'(1) << w_grant_idx) : '0;

    // ---------------- datapath / events ----------------
    assign w_accept = trigger_valid && trigger_out && r_tag_valid[ENGINE_LAT-1]
                      && (r_state == c_ST_ARMED) && !abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant     <= CW'(NUM_CHANNELS - 1);
            r_data_in        <= '0;
            r_channel_in     <= '0;
            r_data_valid     <= 1'b0;
            r_sample_count   <= '0;
            r_evt_valid      <= 1'b0;
            r_evt_channel    <= '0;
            r_evt_confidence <= '0;
            r_holdoff        <= '0;
        end else begin
            r_data_valid <= w_xfer;
            if (w_xfer) begin
                r_data_in    <= w_sel_data;
                r_channel_in <= w_grant_idx;
                r_last_grant <= w_grant_idx;
            end

            if (w_arm_go)
                r_sample_count <= '0;
            else if (w_xfer && (r_sample_count != 16'hFFFF))
                r_sample_count <= r_sample_count + 16'd1;

            r_evt_valid <= w_accept;
            if (w_accept) begin
                r_evt_channel    <= r_tag_chan[ENGINE_LAT-1];
                r_evt_confidence <= trigger_confidence;
            end

            if (w_accept && !single_shot)
                r_holdoff <= holdoff_cycles;
            else if ((r_state == c_ST_HOLDOFF) && (r_holdoff != 16'd0))
                r_holdoff <= r_holdoff - 16'd1;
        end
    end

    // Tag pipeline mirrors the engine latency so the tap lines up with trigger_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_valid <= '0;
            for (int i = 0; i < ENGINE_LAT; i++) r_tag_chan[i] <= '0;
        end else begin
            for (int i = ENGINE_LAT - 1; i > 0; i--) begin
                r_tag_valid[i] <= w_arm_go ? 1'b0 : r_tag_valid[i-1];
                r_tag_chan[i]  <= r_tag_chan[i-1];
            end
            r_tag_valid[0] <= w_arm_go ? 1'b0 : r_data_valid;
            r_tag_chan[0]  <= r_channel_in;
        end
    end

    assign data_in        = r_data_in;
    assign channel_in     = r_channel_in;
    assign data_valid     = r_data_valid;
    assign evt_valid      = r_evt_valid;
    assign evt_channel    = r_evt_channel;
    assign evt_confidence = r_evt_confidence;
    assign sample_count   = r_sample_count;

endmodule
`default_nettype wire

// File: tb/tb_trig_channel_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_trig_channel_scheduler
//  Description : Self-checking bench with a cycle-indexed behavioural model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_trig_channel_scheduler;
    localparam int N  = 16;
    localparam int W  = 12;
    localparam int L  = 2;
    localparam int CW = 4;
    localparam int S_IDLE = 0, S_ARMED = 1, S_HOLD = 2, S_DONE = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    trig_channel_scheduler_if #(.NUM_CHANNELS(N), .ADC_WIDTH(W)) req_if ();

    logic [N-1:0]  chan_mask = '0;
    logic          arm = 1'b0, abort = 1'b0, single_shot = 1'b0;
    logic [15:0]   holdoff_cycles = '0;
    logic [W-1:0]  data_in;
    logic [CW-1:0] channel_in;
    logic          data_valid;
    logic          trigger_valid = 1'b0, trigger_out = 1'b0;
    logic [7:0]    trigger_confidence = '0;
    logic          evt_valid;
    logic [CW-1:0] evt_channel;
    logic [7:0]    evt_confidence;
    logic [1:0]    state_o;
    logic [15:0]   sample_count;

    trig_channel_scheduler #(.NUM_CHANNELS(N), .ADC_WIDTH(W), .ENGINE_LAT(L)) dut (
        .clk(clk), .rst_n(rst_n), .req(req_if),
        .chan_mask(chan_mask), .arm(arm), .abort(abort), .single_shot(single_shot),
        .holdoff_cycles(holdoff_cycles),
        .data_in(data_in), .channel_in(channel_in), .data_valid(data_valid),
        .trigger_valid(trigger_valid), .trigger_out(trigger_out),
        .trigger_confidence(trigger_confidence),
        .evt_valid(evt_valid), .evt_channel(evt_channel), .evt_confidence(evt_confidence),
        .state_o(state_o), .sample_count(sample_count)
    );

    int checks = 0, failures = 0, cyc = 0;

    // stimulus knobs
    logic [N-1:0]   s_valid = '0, s_mask = '0;
    logic [N*W-1:0] s_data = '0;
    logic           s_arm = 0, s_abort = 0, s_ss = 0, spurious = 0;
    logic [15:0]    s_hold = '0;
    int             fire_mode = 0, conf_fixed = -1;

    // behavioural model
    int            m_state, m_last, m_ch, m_cnt, m_evch, m_hold_end, m_arm_cyc;
    logic          m_dv, m_ev;
    logic [W-1:0]  m_data;
    logic [7:0]    m_evconf;
    bit            dvh [8192];
    int            chh [8192];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h cycle=%0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_state = S_IDLE; m_last = N - 1; m_ch = 0; m_cnt = 0; m_evch = 0;
        m_hold_end = 0; m_dv = 0; m_ev = 0; m_data = '0; m_evconf = '0;
        m_arm_cyc = cyc;
    endtask

    task automatic check_outputs(input logic [N-1:0] exp_ready);
        chk("req_ready",      32'(req_if.req_ready), 32'(exp_ready));
        chk("data_valid",     32'(data_valid),       32'(m_dv));
        chk("channel_in",     32'(channel_in),       32'(m_ch));
        chk("data_in",        32'(data_in),          32'(m_data));
        chk("evt_valid",      32'(evt_valid),        32'(m_ev));
        chk("evt_channel",    32'(evt_channel),      32'(m_evch));
        chk("evt_confidence", 32'(evt_confidence),   32'(m_evconf));
        chk("state_o",        32'(state_o),          32'(m_state));
        chk("sample_count",   32'(sample_count),     32'(m_cnt));
    endtask

    task automatic apply_inputs();
        req_if.req_valid = s_valid;
        req_if.req_data  = s_data;
        chan_mask        = s_mask;
        arm              = s_arm;
        abort            = s_abort;
        single_shot      = s_ss;
        holdoff_cycles   = s_hold;
    endtask

    // Reset asserted just after a falling edge: outputs must clear without any clock edge.
    task automatic do_reset(input int n);
        s_arm = 0; s_abort = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (i == 0) rst_n = 1'b0;
            trigger_valid = 0; trigger_out = 0;
            apply_inputs();
            #1;
            model_reset();
            dvh[cyc] = 0; chh[cyc] = 0;
            check_outputs('0);
            cyc++;
        end
        rst_n = 1'b1;
    endtask

    task automatic step();
        int src, g;
        logic tap_v, acc, arm_go;
        int tap_c;
        logic [N-1:0] exp_ready;
        @(negedge clk);
        dvh[cyc] = m_dv; chh[cyc] = m_ch;
        src = cyc - L;
        tap_v = 0; tap_c = 0;
        if (src >= 0) begin
            tap_c = chh[src];
            tap_v = dvh[src] && (src > m_arm_cyc);
        end
        // engine model: answers every sample it saw, regardless of arming
        trigger_valid = 0; trigger_out = 0;
        trigger_confidence = (conf_fixed >= 0) ? 8'(conf_fixed) : 8'($urandom);
        if (src >= 0 && dvh[src]) begin
            trigger_valid = 1;
            trigger_out = (fire_mode == 1) || (fire_mode == 2 && $urandom_range(0, 2) == 0);
        end else if (spurious && $urandom_range(0, 3) == 0) begin
            trigger_valid = 1; trigger_out = 1;
        end
        apply_inputs();
        #1;
        g = -1;
        if (m_state == S_ARMED || m_state == S_HOLD) begin
            for (int k = 1; k <= N; k++) begin
                if (g < 0 && s_valid[(m_last + k) % N] && s_mask[(m_last + k) % N]) g = (m_last + k) % N;
            end
        end
        exp_ready = (g >= 0) ? (N'(1) << g) : '0;
        check_outputs(exp_ready);

        acc    = trigger_valid && trigger_out && tap_v && (m_state == S_ARMED) && !s_abort;
        arm_go = s_arm && !s_abort && (m_state == S_IDLE || m_state == S_DONE);
        m_dv = (g >= 0);
        if (g >= 0) begin
            m_ch = g; m_data = s_data[g*W +: W]; m_last = g;
        end
        if (arm_go) m_cnt = 0;
        else if (g >= 0 && m_cnt != 65535) m_cnt++;
        m_ev = acc;
        if (acc) begin m_evch = tap_c; m_evconf = trigger_confidence; end
        if (s_abort) m_state = S_IDLE;
        else case (m_state)
            S_IDLE, S_DONE: if (s_arm) m_state = S_ARMED;
            S_ARMED: if (acc) begin
                if (s_ss) m_state = S_DONE;
                else begin m_state = S_HOLD; m_hold_end = cyc + 1 + int'(s_hold); end
            end
            S_HOLD: if (cyc >= m_hold_end) m_state = S_ARMED;
            default: m_state = S_IDLE;
        endcase
        if (arm_go) m_arm_cyc = cyc;
        cyc++;
        s_arm = 0; s_abort = 0;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        req_if.req_valid = '0;
        req_if.req_data  = '0;
        // reset with every channel requesting
        s_valid = '1; s_mask = '1;
        do_reset(10);
        steps(3);

        // round-robin over channels 0, 3, 7
        s_valid = 16'h0089; s_mask = 16'hFFFF; fire_mode = 0;
        for (int i = 0; i < N; i++) s_data[i*W +: W] = W'(i * 100 + 7);
        s_arm = 1; step();
        steps(30);
        s_valid = '0; step();
        chk("rr_sample_count", 32'(sample_count), 32'd30);

        // masking
        s_valid = '1; s_mask = 16'h000F; steps(12);
        s_mask = 16'h0010; steps(6);

        // trigger tagging on channel 5
        s_abort = 1; s_valid = '0; step();
        s_mask = '1; fire_mode = 1; conf_fixed = 200;
        s_arm = 1; step();
        s_valid = 16'h0020; s_data[5*W +: W] = 12'd3000; step();
        s_valid = '0; steps(L + 2);
        chk("tag_evt_valid",   32'(evt_valid),      32'd1);
        chk("tag_evt_channel", 32'(evt_channel),    32'd5);
        chk("tag_evt_conf",    32'(evt_confidence), 32'd200);
        conf_fixed = -1;

        // holdoff, then single shot
        s_abort = 1; step();
        s_ss = 0; s_hold = 16'd4; s_valid = '1; s_arm = 1; steps(25);
        s_abort = 1; step();
        s_ss = 1; s_arm = 1; steps(15);
        chk("ss_state_done", 32'(state_o),    32'd3);
        chk("ss_dv_low",     32'(data_valid), 32'd0);

        // abort coinciding with a qualifying trigger
        s_abort = 1; step();
        s_ss = 0; s_arm = 1; step();
        steps(L + 1);
        s_abort = 1; step();
        step();
        chk("abort_no_evt", 32'(evt_valid), 32'd0);
        chk("abort_idle",   32'(state_o),   32'd0);

        // reset in the middle of holdoff
        s_hold = 16'd20; s_arm = 1; step();
        for (int i = 0; i < 50 && state_o != 2'd2; i++) step();
        chk("reach_holdoff", 32'(state_o), 32'd2);
        step();
        do_reset(3);
        s_arm = 1; step();
        chk("rearm_count_zero", 32'(sample_count), 32'd0);
        steps(5);

        // randomized operation
        spurious = 1; fire_mode = 2;
        for (int n = 0; n < 1500; n++) begin
            s_valid = N'($urandom);
            for (int i = 0; i < N; i++) s_data[i*W +: W] = W'($urandom);
            if ($urandom_range(0, 15) == 0) s_mask = N'($urandom);
            if ($urandom_range(0, 19) == 0) s_arm = 1;
            if ($urandom_range(0, 59) == 0) s_abort = 1;
            if ($urandom_range(0, 39) == 0) s_ss = ~s_ss;
            if ($urandom_range(0, 29) == 0) s_hold = 16'($urandom_range(0, 6));
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/trig_channel_scheduler.md
# trig_channel_scheduler

Round-robin channel scheduler in front of `derivative_threshold_engine`. It arbitrates up to NUM_CHANNELS per-channel ADC sample streams into the engine's single `data_in`/`channel_in`/`data_valid` port, at one sample per cycle. It tags the engine's trigger outputs with the originating channel and sequences acquisition through an arm / holdoff / single-shot state machine. It sits between the ADC capture front end and the trigger engine; its event outputs feed the capture-buffer controller.

## Interface
- NUM_CHANNELS, 16: number of requesting channels; power of two, 2..16.
- ADC_WIDTH, 12: sample width.
- ENGINE_LAT, 2: cycles from `data_valid` high to the matching `trigger_valid` from the engine; valid range 1..8.
- CW, $clog2(NUM_CHANNELS): channel index width (derived, not overridable).

Ports (name, direction, width, meaning):
- clk  in  1  single clock; all logic on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_CHANNELS  per-channel sample available.
- req_data  in  NUM_CHANNELS*ADC_WIDTH  flattened samples; channel i at [i*ADC_WIDTH +: ADC_WIDTH].
- req_ready  out  NUM_CHANNELS  one-hot grant; a transfer occurs when req_valid[i] & req_ready[i].
- chan_mask  in  NUM_CHANNELS  1 = channel eligible for arbitration.
- arm  in  1  one-cycle pulse: start acquisition.
- abort  in  1  one-cycle pulse: return to IDLE.
- single_shot  in  1  1 = stop after the first accepted trigger.
- holdoff_cycles  in  16  cycles during which triggers are ignored after an accepted trigger.
- data_in  out  ADC_WIDTH  to engine.
- channel_in  out  CW  to engine.
- data_valid  out  1  to engine.
- trigger_valid  in  1  from engine.
- trigger_out  in  1  from engine.
- trigger_confidence  in  8  from engine.
- evt_valid  out  1  one-cycle pulse per accepted trigger.
- evt_channel  out  CW  channel that caused the event.
- evt_confidence  out  8  latched trigger_confidence.
- state_o  out  2  current state: IDLE=0, ARMED=1, HOLDOFF=2, DONE=3.
- sample_count  out  16  samples issued since last arm; saturates at 0xFFFF.

## Operation
- States and transitions:
  - IDLE: no issuing. arm → ARMED; sample_count and the tag pipeline are cleared on that transition.
  - ARMED: issuing; triggers accepted. An accepted trigger → DONE if single_shot, else HOLDOFF.
  - HOLDOFF: issuing continues; triggers are ignored; the holdoff counter is loaded with holdoff_cycles and decrements each cycle. Counter == 0 → ARMED. holdoff_cycles == 0 → return to ARMED on the next cycle.
  - DONE: no issuing. arm → ARMED.
  - abort in any state → IDLE next cycle. abort has priority over arm and over trigger acceptance in the same cycle.
- Issuing is enabled in ARMED and HOLDOFF only.
- Arbitration is combinational over `req_valid & chan_mask`. The search starts at channel (last_grant+1), wraps modulo NUM_CHANNELS, and selects the first eligible channel. At most one req_ready bit is high. All req_ready bits are 0 when issuing is disabled or no channel is eligible.
- last_grant updates only on a completed transfer. Its reset value is NUM_CHANNELS-1, so channel 0 has first priority.
- A transfer registers data_in, channel_in, data_valid=1 for the next cycle and increments sample_count (saturating). A cycle with no transfer sets data_valid=0; data_in and channel_in hold their previous values.
- Tag pipeline: ENGINE_LAT-deep shift of {data_valid, channel_in}, advancing every cycle. The tap entry is aligned with trigger_valid.
- A trigger is accepted when all of the following hold: trigger_valid & trigger_out & tap.valid & state==ARMED & !abort. On acceptance, the next cycle has evt_valid=1, evt_channel=tap.channel, evt_confidence=trigger_confidence.
- trigger_valid with tap.valid=0 is discarded.
- A chan_mask change takes effect on the next arbitration. Samples already in the engine still produce events.

## Timing
- Reset values: req_ready=0, data_valid=0, data_in=0, channel_in=0, evt_valid=0, evt_channel=0, evt_confidence=0, state_o=IDLE, sample_count=0, holdoff counter=0, tag pipeline valid bits=0.
- Handshake to data_valid: 1 cycle.
- Handshake to evt_valid: ENGINE_LAT+2 cycles (1 cycle to data_valid, ENGINE_LAT to trigger_valid, 1 cycle registered event).
- Throughput: one sample per cycle with no bubbles when any eligible channel is valid.
- State change on accept: registered in the same edge as evt_valid. The holdoff count begins on the first HOLDOFF cycle.
- ARMED → DONE: data_valid goes low the cycle after entry into DONE; the in-flight engine pipeline drains, and any triggers from it are ignored.
- Reset asserted mid-operation clears all state immediately (asynchronously). There is no partial event.

## Test plan
- Reset and idle: hold rst_n=0 for 10 cycles with req_valid=0xFFFF → all outputs at reset values. Release reset without arm → req_ready stays 0 and state_o=0.
- Round-robin fairness: arm; mask=0xFFFF; channels 0, 3, 7 always valid → grants cycle 0,3,7,0,3,7…; channel_in matches one cycle later; sample_count=30 after 30 cycles.
- Masking: mask=0x000F; all 16 channels valid → only channels 0–3 are granted. Changing mask to 0x0010 → only channel 4 is granted from the next cycle.
- Trigger tagging: ENGINE_LAT=2; channel 5 issues data_in=3000; engine model returns trigger_valid=trigger_out=1, confidence=200 two cycles after its data_valid → evt_valid with evt_channel=5, evt_confidence=200, ENGINE_LAT+2 cycles after the handshake.
- Holdoff: single_shot=0, holdoff_cycles=4; triggers on every sample → one event, then 4 cycles with no events, then ARMED and the next event accepted. With single_shot=1 → one event, state DONE, data_valid=0 afterwards.
- Abort and mid-reset: abort in the same cycle as a qualifying trigger → no evt_valid, state IDLE. Assert rst_n low during HOLDOFF → immediate reset values; after re-arm, sample_count restarts at 0.
